// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared constants, FSM state type and round-robin pick helper for rr_grant_ctrl8
package arb_pkg;

  localparam int N_REQ       = 8;
  localparam int IDX_W       = 3;
  localparam int TIMEOUT_DEF = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Rotate req so that bit ptr lands at position 0, then take the lowest set bit.
  // The result is that offset added back onto ptr. The 3-bit add wraps mod 8.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                               input logic [IDX_W-1:0] ptr);
    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [IDX_W-1:0]   off;
    dbl = {req, req};
    rot = dbl[ptr +: N_REQ];
    off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = IDX_W'(i);
    end
    return ptr + off;
  endfunction

endpackage

// File: rtl/rr_grant_ctrl8_if.sv
// rtl/rr_grant_ctrl8_if.sv - request/grant bundle between requesters (master) and the arbiter (slave)
interface rr_grant_ctrl8_if;
  import arb_pkg::*;

  logic [N_REQ-1:0] req;
  logic             done;
  logic [N_REQ-1:0] gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_vld;
  logic             busy;
  logic             timeout;

  modport master (
    output req, done,
    input  gnt, gnt_idx, gnt_vld, busy, timeout
  );

  modport slave (
    input  req, done,
    output gnt, gnt_idx, gnt_vld, busy, timeout
  );

endinterface

// File: rtl/onehot_dec3_8.sv
// rtl/onehot_dec3_8.sv - 3-to-8 one-hot decoder with enable, fed from registered index/valid
module onehot_dec3_8
  import arb_pkg::*;
(
  input  logic             en,
  input  logic [IDX_W-1:0] idx,
  output logic [N_REQ-1:0] onehot
);

  // Select line for the winner; all lines low while no grant is active.
  always_comb begin
    onehot = '0;
    if (en) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/rr_grant_ctrl8.sv
// rtl/rr_grant_ctrl8.sv - 8-way round-robin arbiter with held grant; optional forced release under ARB_TIMEOUT_EN
module rr_grant_ctrl8
  import arb_pkg::*;
`ifdef ARB_TIMEOUT_EN
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
)
`endif
(
  input  logic         clk,
  input  logic         rst_n,
  rr_grant_ctrl8_if.slave bus
);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             rel_c;

`ifdef ARB_TIMEOUT_EN
  logic [7:0] cnt_q;
  logic       timeout_q, timeout_d;
`endif

  // Next-state logic: arbitrate in IDLE, hold the owner in GRANT until it releases.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    rel_c   = 1'b0;
`ifdef ARB_TIMEOUT_EN
    timeout_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          state_d = GRANT;
          idx_d   = rr_pick(bus.req, ptr_q);
        end
      end
      GRANT: begin
        // done and a withdrawn request together still count as one release.
        if (bus.done || !bus.req[idx_q]) begin
          rel_c = 1'b1;
        end
`ifdef ARB_TIMEOUT_EN
        else if (cnt_q == 8'(TIMEOUT - 1)) begin
          rel_c     = 1'b1;
          timeout_d = 1'b1;
        end
`endif
        if (rel_c) begin
          state_d = IDLE;
          ptr_d   = idx_q + 3'd1;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // State, priority pointer and winner index registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Hold counter: zero while idle so it starts from 0 on the first GRANT cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_d;
      if (state_q == IDLE) cnt_q <= '0;
      else                 cnt_q <= cnt_q + 8'd1;
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign bus.timeout = 1'b0;
`endif

  assign bus.gnt_idx = idx_q;
  assign bus.gnt_vld = (state_q == GRANT);
  assign bus.busy    = (state_q == GRANT);

  onehot_dec3_8 u_dec (
    .en     (state_q == GRANT),
    .idx    (idx_q),
    .onehot (bus.gnt)
  );

endmodule

// File: tb/tb_rr_grant_ctrl8.sv
// tb/tb_rr_grant_ctrl8.sv - directed self-checking bench for rr_grant_ctrl8 (ARB_TIMEOUT_EN steps when defined)
module tb_rr_grant_ctrl8;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  rr_grant_ctrl8_if bus ();

`ifdef ARB_TIMEOUT_EN
  rr_grant_ctrl8 #(.TIMEOUT(4)) dut (
`else
  rr_grant_ctrl8 dut (
`endif
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected grant g (one-hot or 0) and expected timeout pulse.
  task automatic chk_grant(input string tag, input logic [7:0] g, input logic to);
    logic [2:0] ei;
    ei = 3'd0;
    for (int i = 0; i < 8; i++) if (g[i]) ei = 3'(i);
    chk({tag, ".gnt"},     32'(bus.gnt),     32'(g));
    chk({tag, ".gnt_vld"}, 32'(bus.gnt_vld), 32'(g != 8'h00));
    chk({tag, ".busy"},    32'(bus.busy),    32'(g != 8'h00));
    chk({tag, ".timeout"}, 32'(bus.timeout), 32'(to));
    if (g != 8'h00) chk({tag, ".gnt_idx"}, 32'(bus.gnt_idx), 32'(ei));
  endtask

  initial begin
    rst_n    = 1'b0;
    bus.req  = 8'h00;
    bus.done = 1'b0;
    step();
    step();
    chk_grant("reset", 8'h00, 1'b0);
    chk("reset.gnt_idx", 32'(bus.gnt_idx), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      step();
      chk_grant("idle_noreq", 8'h00, 1'b0);
    end

    bus.done = 1'b1;
    step();
    chk_grant("done_in_idle", 8'h00, 1'b0);
    bus.done = 1'b0;

    bus.req = 8'h24;
    step();
    chk_grant("req24_first", 8'h04, 1'b0);
    step();
    chk_grant("req24_hold", 8'h04, 1'b0);
    bus.done = 1'b1;
    step();
    chk_grant("req24_release", 8'h00, 1'b0);
    bus.done = 1'b0;
    step();
    chk_grant("req24_second", 8'h20, 1'b0);
    bus.req = 8'h00;
    step();
    chk_grant("withdraw_release", 8'h00, 1'b0);

    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    bus.req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      step();
      chk_grant($sformatf("rot_gnt%0d", k), 8'(1 << (k % 8)), 1'b0);
      bus.done = 1'b1;
      step();
      chk_grant($sformatf("rot_gap%0d", k), 8'h00, 1'b0);
      bus.done = 1'b0;
    end
    bus.req = 8'h00;
    step();

    bus.req = 8'h08;
    step();
    chk_grant("own3", 8'h08, 1'b0);
    bus.req = 8'h0A;
    step();
    chk_grant("own3_ignore_req1", 8'h08, 1'b0);
    bus.req = 8'h02;
    step();
    chk_grant("own3_withdraw", 8'h00, 1'b0);
    step();
    chk_grant("wrap_to_1", 8'h02, 1'b0);
    bus.req = 8'h00;
    step();
    chk_grant("rel1", 8'h00, 1'b0);

    bus.req = 8'h08;
    step();
    chk_grant("own3_again", 8'h08, 1'b0);
    bus.req  = 8'h12;
    bus.done = 1'b1;
    step();
    chk_grant("dual_release", 8'h00, 1'b0);
    bus.done = 1'b0;
    step();
    chk_grant("single_advance", 8'h10, 1'b0);
    bus.req = 8'h00;
    step();
    chk_grant("rel4", 8'h00, 1'b0);

    bus.req = 8'h01;
    step();
    chk_grant("hold_c1", 8'h01, 1'b0);
`ifdef ARB_TIMEOUT_EN
    for (int c = 2; c <= 4; c++) begin
      step();
      chk_grant($sformatf("hold_c%0d", c), 8'h01, 1'b0);
    end
    step();
    chk_grant("forced_release", 8'h00, 1'b1);
    step();
    chk_grant("regrant0", 8'h01, 1'b0);
    step();
    step();
    step();
    chk_grant("regrant0_c4", 8'h01, 1'b0);
    bus.done = 1'b1;
    step();
    chk_grant("done_beats_timeout", 8'h00, 1'b0);
    bus.done = 1'b0;
`else
    for (int c = 2; c <= 20; c++) begin
      step();
      chk_grant($sformatf("hold_c%0d", c), 8'h01, 1'b0);
    end
    bus.done = 1'b1;
    step();
    chk_grant("hold_release", 8'h00, 1'b0);
    bus.done = 1'b0;
`endif
    bus.req = 8'h00;
    step();

    bus.req = 8'h80;
    step();
    chk_grant("own7", 8'h80, 1'b0);
    rst_n   = 1'b0;
    bus.req = 8'h81;
    step();
    chk_grant("mid_reset", 8'h00, 1'b0);
    chk("mid_reset.gnt_idx", 32'(bus.gnt_idx), 32'd0);
    rst_n = 1'b1;
    step();
    chk_grant("post_reset_ptr0", 8'h01, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
